// File: rtl/td4_prog_loader.sv
// td4_prog_loader: write side of the TD4 16x8 program memory.
// Fills the program store from a valid/ready byte stream, serves the CPU
// fetch port as an asynchronous-read memory and holds the CPU in reset
// while a program is being loaded.
// Optional build macro: LOADER_CHKSUM_EN -- each load carries a trailing
// checksum byte; a bad sum parks the loader in an error state.
module td4_prog_loader #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              clr_n_i,
   input  logic              load_req_i,
   input  logic              run_req_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   output logic [DATA_W-1:0] cpu_data_o,
   output logic              cpu_clr_n_o,
   output logic [ADDR_W-1:0] wptr_o,
   output logic              loaded_o,
   output logic              err_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_ERROR = 2'd3
   } state_e;

   state_e              state_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [ADDR_W-1:0]   wptr_q;
   logic                in_ready_q;
   logic                cpu_clr_n_q;
   logic                loaded_q;
   logic                hs;

`ifdef LOADER_CHKSUM_EN
   logic [DATA_W-1:0]   sum_q;
   logic [DATA_W-1:0]   sum_total;
   logic                chk_phase_q;
   logic                err_q;

   // Running sum including the byte on the bus; zero means a good checksum.
   assign sum_total = sum_q + in_data_i;
`endif

   // A byte is taken only when the loader advertised ready this cycle.
   assign hs = in_valid_i & in_ready_q;

   // Loader FSM, program store and all registered outputs.
   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         state_q     <= S_IDLE;
         wptr_q      <= '0;
         in_ready_q  <= 1'b0;
         cpu_clr_n_q <= 1'b0;
         loaded_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef LOADER_CHKSUM_EN
         sum_q       <= '0;
         chk_phase_q <= 1'b0;
         err_q       <= 1'b0;
`endif
      end else begin
         loaded_q <= 1'b0;
         if (load_req_i) begin
            // Load request wins from every state; a byte offered now is dropped.
            state_q     <= S_LOAD;
            wptr_q      <= '0;
            in_ready_q  <= 1'b1;
            cpu_clr_n_q <= 1'b0;
`ifdef LOADER_CHKSUM_EN
            sum_q       <= '0;
            chk_phase_q <= 1'b0;
            err_q       <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_IDLE: begin
                  cpu_clr_n_q <= 1'b0;
                  in_ready_q  <= 1'b0;
                  if (run_req_i) begin
                     state_q <= S_RUN;
                  end
               end
               S_LOAD: begin
                  cpu_clr_n_q <= 1'b0;
                  if (hs) begin
`ifdef LOADER_CHKSUM_EN
                     if (!chk_phase_q) begin
                        mem_q[wptr_q] <= in_data_i;
                        sum_q         <= sum_total;
                        wptr_q        <= wptr_q + ADDR_W'(1);
                        if (wptr_q == WPTR_LAST) begin
                           chk_phase_q <= 1'b1;
                        end
                     end else begin
                        // Checksum byte: verified, never stored.
                        chk_phase_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                        if (sum_total == '0) begin
                           state_q  <= S_RUN;
                           loaded_q <= 1'b1;
                        end else begin
                           state_q <= S_ERROR;
                           err_q   <= 1'b1;
                        end
                     end
`else
                     mem_q[wptr_q] <= in_data_i;
                     wptr_q        <= wptr_q + ADDR_W'(1);
                     if (wptr_q == WPTR_LAST) begin
                        state_q    <= S_RUN;
                        loaded_q   <= 1'b1;
                        in_ready_q <= 1'b0;
                     end
`endif
                  end
               end
               S_RUN: begin
                  // Release is one cycle after entering RUN.
                  cpu_clr_n_q <= 1'b1;
                  in_ready_q  <= 1'b0;
               end
`ifdef LOADER_CHKSUM_EN
               S_ERROR: begin
                  cpu_clr_n_q <= 1'b0;
                  in_ready_q  <= 1'b0;
               end
`endif
               default: begin
                  state_q     <= S_IDLE;
                  cpu_clr_n_q <= 1'b0;
                  in_ready_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Fetch port: zero-latency read, old data on same-address write.
   assign cpu_data_o  = mem_q[cpu_addr_i];
   assign in_ready_o  = in_ready_q;
   assign cpu_clr_n_o = cpu_clr_n_q;
   assign wptr_o      = wptr_q;
   assign loaded_o    = loaded_q;
`ifdef LOADER_CHKSUM_EN
   assign err_o       = err_q;
`else
   assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed self-checking bench for td4_prog_loader (both macro builds).
module tb_td4_prog_loader;

`ifdef LOADER_CHKSUM_EN
   localparam bit CHK_BUILD = 1'b1;
`else
   localparam bit CHK_BUILD = 1'b0;
`endif

   logic       clk;
   logic       clr_n;
   logic       load_req;
   logic       run_req;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] cpu_addr;
   logic [7:0] cpu_data;
   logic       cpu_clr_n;
   logic [3:0] wptr;
   logic       loaded;
   logic       err;

   int checks = 0;
   int failures = 0;
   int loaded_cnt = 0;

   td4_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk_i       (clk),
      .clr_n_i     (clr_n),
      .load_req_i  (load_req),
      .run_req_i   (run_req),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .cpu_addr_i  (cpu_addr),
      .cpu_data_o  (cpu_data),
      .cpu_clr_n_o (cpu_clr_n),
      .wptr_o      (wptr),
      .loaded_o    (loaded),
      .err_o       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count completion pulses away from the active edge.
   always @(negedge clk) if (loaded === 1'b1) loaded_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      cyc();
      load_req = 1'b0;
   endtask

   task automatic pulse_run();
      run_req = 1'b1;
      cyc();
      run_req = 1'b0;
   endtask

   task automatic apply_reset();
      clr_n = 1'b0;
      cyc();
      clr_n = 1'b1;
      cyc();
   endtask

   // Ends a load after the data bytes: sends the checksum when enabled.
   task automatic close_load(input logic [7:0] sum);
`ifdef LOADER_CHKSUM_EN
      in_valid = 1'b1;
      in_data  = 8'(~sum + 8'd1);
      cyc();
      in_valid = 1'b0;
`else
      in_data = sum;
`endif
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      cyc();
      cpu_addr = 4'd0;
      #1;
      checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL reset_wptr got=%0h exp=0", wptr); end
      checks++; if (cpu_clr_n !== 1'b0) begin failures++; $display("FAIL reset_cpu_clr_n got=%b exp=0", cpu_clr_n); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (loaded !== 1'b0) begin failures++; $display("FAIL reset_loaded got=%b exp=0", loaded); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (cpu_data !== 8'h00) begin failures++; $display("FAIL reset_cpu_data got=%h exp=00", cpu_data); end
      clr_n = 1'b1;
      cyc();
      // Partial load, then reset in mid-cycle.
      pulse_load();
      in_valid = 1'b1;
      in_data = 8'h11; cyc();
      in_data = 8'h22; cyc();
      in_data = 8'h33; cyc();
      in_valid = 1'b0;
      #1;
      checks++; if (wptr !== 4'd3) begin failures++; $display("FAIL midload_wptr got=%0h exp=3", wptr); end
      checks++; if (cpu_data !== 8'h11) begin failures++; $display("FAIL midload_read0 got=%h exp=11", cpu_data); end
      @(posedge clk);
      #3;
      clr_n = 1'b0;
      #1;
      checks++; if (cpu_clr_n !== 1'b0) begin failures++; $display("FAIL async_rst_cpu_clr_n got=%b exp=0", cpu_clr_n); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL async_rst_in_ready got=%b exp=0", in_ready); end
      checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL async_rst_wptr got=%0h exp=0", wptr); end
      checks++; if (cpu_data !== 8'h00) begin failures++; $display("FAIL async_rst_cpu_data got=%h exp=00", cpu_data); end
      cyc();
      clr_n = 1'b1;
      cyc();
   endtask

   task automatic test_full_load();
      int l0;
      l0 = loaded_cnt;
      pulse_load();
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(i);
         cyc();
      end
      in_valid = 1'b0;
      checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL full_wptr_wrap got=%0h exp=0", wptr); end
      close_load(8'h78);
      checks++; if (loaded !== 1'b1) begin failures++; $display("FAIL full_loaded got=%b exp=1", loaded); end
      checks++; if (cpu_clr_n !== 1'b0) begin failures++; $display("FAIL full_first_run_clr got=%b exp=0", cpu_clr_n); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      cyc();
      checks++; if (cpu_clr_n !== 1'b1) begin failures++; $display("FAIL full_release got=%b exp=1", cpu_clr_n); end
      checks++; if (loaded !== 1'b0) begin failures++; $display("FAIL full_loaded_drop got=%b exp=0", loaded); end
      checks++; if (loaded_cnt - l0 !== 1) begin failures++; $display("FAIL full_loaded_count got=%0d exp=1", loaded_cnt - l0); end
      cpu_addr = 4'd5; #1;
      checks++; if (cpu_data !== 8'h05) begin failures++; $display("FAIL full_read5 got=%h exp=05", cpu_data); end
      cpu_addr = 4'd15; #1;
      checks++; if (cpu_data !== 8'h0F) begin failures++; $display("FAIL full_read15 got=%h exp=0f", cpu_data); end
   endtask

   task automatic test_backpressure();
      logic exp_rdy;
      pulse_load();
      checks++; if (cpu_clr_n !== 1'b0) begin failures++; $display("FAIL bp_run_to_load_clr got=%b exp=0", cpu_clr_n); end
      checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL bp_start_wptr got=%0h exp=0", wptr); end
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data = 8'(8'hA0 + i);
         cyc();
         exp_rdy = (i < 15) || CHK_BUILD;
         checks++; if (wptr !== 4'(i + 1)) begin failures++; $display("FAIL bp_wptr_%0d got=%0h exp=%0h", i, wptr, 4'(i + 1)); end
         checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL bp_ready_%0d got=%b exp=%b", i, in_ready, exp_rdy); end
         if (i < 15) begin
            in_valid = 1'b0;
            in_data = 8'h55;
            cyc();
            checks++; if (wptr !== 4'(i + 1)) begin failures++; $display("FAIL bp_hold_%0d got=%0h exp=%0h", i, wptr, 4'(i + 1)); end
         end
      end
      in_valid = 1'b0;
      close_load(8'h78);
      checks++; if (loaded !== 1'b1) begin failures++; $display("FAIL bp_loaded got=%b exp=1", loaded); end
      cyc();
      checks++; if (cpu_clr_n !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", cpu_clr_n); end
      cpu_addr = 4'd3; #1;
      checks++; if (cpu_data !== 8'hA3) begin failures++; $display("FAIL bp_read3 got=%h exp=a3", cpu_data); end
      cpu_addr = 4'd10; #1;
      checks++; if (cpu_data !== 8'hAA) begin failures++; $display("FAIL bp_read10 got=%h exp=aa", cpu_data); end
   endtask

   task automatic test_restart();
      pulse_load();
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_data = 8'(8'h30 + i);
         cyc();
      end
      load_req = 1'b1;
      in_data = 8'h37;
      cyc();
      load_req = 1'b0;
      in_valid = 1'b0;
      checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL restart_wptr got=%0h exp=0", wptr); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL restart_ready got=%b exp=1", in_ready); end
      cpu_addr = 4'd7; #1;
      checks++; if (cpu_data !== 8'hA7) begin failures++; $display("FAIL restart_byte7_dropped got=%h exp=a7", cpu_data); end
      cpu_addr = 4'd6; #1;
      checks++; if (cpu_data !== 8'h36) begin failures++; $display("FAIL restart_kept6 got=%h exp=36", cpu_data); end
      cpu_addr = 4'd0; #1;
      checks++; if (cpu_data !== 8'h30) begin failures++; $display("FAIL restart_kept0 got=%h exp=30", cpu_data); end
      in_valid = 1'b1;
      in_data = 8'hFF;
      for (int i = 0; i < 16; i++) begin
         if (i == 4) begin
            cpu_addr = 4'd4; #1;
            checks++; if (cpu_data !== 8'h34) begin failures++; $display("FAIL rdw_old got=%h exp=34", cpu_data); end
         end
         cyc();
         if (i == 4) begin
            checks++; if (cpu_data !== 8'hFF) begin failures++; $display("FAIL rdw_new got=%h exp=ff", cpu_data); end
         end
      end
      in_valid = 1'b0;
      close_load(8'hF0);
      cyc();
      checks++; if (cpu_clr_n !== 1'b1) begin failures++; $display("FAIL reload_release got=%b exp=1", cpu_clr_n); end
      for (int a = 0; a < 16; a++) begin
         cpu_addr = 4'(a); #1;
         checks++; if (cpu_data !== 8'hFF) begin failures++; $display("FAIL reload_read_%0d got=%h exp=ff", a, cpu_data); end
      end
   endtask

   task automatic test_run_req();
      apply_reset();
      pulse_run();
      checks++; if (cpu_clr_n !== 1'b0) begin failures++; $display("FAIL run_first_cycle got=%b exp=0", cpu_clr_n); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL run_ready got=%b exp=0", in_ready); end
      cyc();
      checks++; if (cpu_clr_n !== 1'b1) begin failures++; $display("FAIL run_release got=%b exp=1", cpu_clr_n); end
      for (int a = 0; a < 16; a++) begin
         cpu_addr = 4'(a); #1;
         checks++; if (cpu_data !== 8'h00) begin failures++; $display("FAIL run_read_%0d got=%h exp=00", a, cpu_data); end
      end
      pulse_run();
      checks++; if (cpu_clr_n !== 1'b1) begin failures++; $display("FAIL run_req_in_run got=%b exp=1", cpu_clr_n); end
      pulse_load();
      checks++; if (cpu_clr_n !== 1'b0) begin failures++; $display("FAIL run_load_clr got=%b exp=0", cpu_clr_n); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL run_load_ready got=%b exp=1", in_ready); end
      pulse_run();
      cyc();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL load_ignores_run_ready got=%b exp=1", in_ready); end
      checks++; if (cpu_clr_n !== 1'b0) begin failures++; $display("FAIL load_ignores_run_clr got=%b exp=0", cpu_clr_n); end
      apply_reset();
      load_req = 1'b1;
      run_req = 1'b1;
      cyc();
      load_req = 1'b0;
      run_req = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL both_req_load_wins got=%b exp=1", in_ready); end
      cyc();
      checks++; if (cpu_clr_n !== 1'b0) begin failures++; $display("FAIL both_req_clr got=%b exp=0", cpu_clr_n); end
   endtask

`ifdef LOADER_CHKSUM_EN
   task automatic test_chksum();
      pulse_load();
      in_valid = 1'b1;
      in_data = 8'h01;
      repeat (16) cyc();
      checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL chk_wait_wptr got=%0h exp=0", wptr); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL chk_wait_ready got=%b exp=1", in_ready); end
      in_data = 8'hF0;
      cyc();
      in_valid = 1'b0;
      checks++; if (loaded !== 1'b1) begin failures++; $display("FAIL chk_good_loaded got=%b exp=1", loaded); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL chk_good_err got=%b exp=0", err); end
      cyc();
      checks++; if (cpu_clr_n !== 1'b1) begin failures++; $display("FAIL chk_good_release got=%b exp=1", cpu_clr_n); end
      cpu_addr = 4'd0; #1;
      checks++; if (cpu_data !== 8'h01) begin failures++; $display("FAIL chk_read0 got=%h exp=01", cpu_data); end
      pulse_load();
      in_valid = 1'b1;
      in_data = 8'h01;
      repeat (16) cyc();
      in_data = 8'hF1;
      cyc();
      in_valid = 1'b0;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL chk_bad_err got=%b exp=1", err); end
      checks++; if (loaded !== 1'b0) begin failures++; $display("FAIL chk_bad_loaded got=%b exp=0", loaded); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL chk_bad_ready got=%b exp=0", in_ready); end
      pulse_run();
      cyc();
      checks++; if (cpu_clr_n !== 1'b0) begin failures++; $display("FAIL chk_err_clr got=%b exp=0", cpu_clr_n); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL chk_err_hold got=%b exp=1", err); end
      pulse_load();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL chk_err_cleared got=%b exp=0", err); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL chk_reload_ready got=%b exp=1", in_ready); end
   endtask
`endif

   initial begin
      clr_n    = 1'b0;
      load_req = 1'b0;
      run_req  = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      cpu_addr = 4'd0;
      test_reset();
      test_full_load();
      test_backpressure();
      test_restart();
      test_run_req();
`ifdef LOADER_CHKSUM_EN
      test_chksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
- Write side of the TD4 program memory. Fills a 16 x 8 program store one byte at a time from a valid/ready byte stream, such as a UART receiver or a switch-entry front end.
- Serves the CPU's fetch port as an asynchronous-read memory, so it is a drop-in replacement for the fixed program ROM.
- Holds the CPU in reset while loading and releases it when the load completes.

Parameters:
- ADDR_W, 4, program address width; DEPTH = 2**ADDR_W bytes.
- DATA_W, 8, instruction width.

Ports:
- CLK  in  1  system clock, the same clock as the 1 Hz enable generator.
- CLR_N  in  1  asynchronous active-low reset.
- LOAD_REQ  in  1  single-cycle pulse; starts or restarts a program load.
- RUN_REQ  in  1  single-cycle pulse; releases the CPU without loading.
- IN_DATA  in  DATA_W  incoming program byte.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  loader accepts a byte this cycle.
- CPU_ADDR  in  ADDR_W  CPU fetch address.
- CPU_DATA  out  DATA_W  instruction at CPU_ADDR.
- CPU_CLR_N  out  1  active-low reset to the CPU.
- WPTR  out  ADDR_W  next write address, for HEX display.
- LOADED  out  1  one-cycle pulse when a load completes.
- ERR  out  1  load error flag.

Behaviour:
- Single clock; reset is asynchronous, active-low (CLR_N).
- States: IDLE, LOAD, RUN, ERROR. ERROR is reachable only with the optional feature.
- Reset values:
  - State IDLE, all DEPTH memory bytes 0, WPTR 0.
  - CPU_CLR_N 0, IN_READY 0, LOADED 0, ERR 0.
  - CPU_DATA reflects the cleared memory, i.e. 0.
- IDLE:
  - CPU_CLR_N = 0.
  - LOAD_REQ -> LOAD with WPTR 0.
  - RUN_REQ -> RUN.
  - If both arrive together, LOAD_REQ wins.
- LOAD:
  - IN_READY = 1; it is a registered decode of state and does not depend on IN_VALID.
  - On a handshake (IN_VALID & IN_READY): mem[WPTR] <= IN_DATA, WPTR <= WPTR + 1.
  - A handshake at WPTR = DEPTH-1: WPTR wraps to 0, next state RUN, LOADED pulses for one cycle (the cycle state becomes RUN).
  - IN_VALID low: hold, no timeout.
  - LOAD_REQ in LOAD restarts the load at WPTR 0. A byte presented in the same cycle is dropped, even though IN_READY was high. Memory already written is not cleared.
  - RUN_REQ is ignored in LOAD.
- RUN:
  - CPU_CLR_N = 1, registered, so the CPU is released one cycle after entry.
  - IN_READY = 0.
  - LOAD_REQ -> LOAD, WPTR 0, CPU_CLR_N back to 0 on the next edge.
  - RUN_REQ is ignored.
- Read port:
  - CPU_DATA = mem[CPU_ADDR], combinational, zero latency.
  - Read and write to the same address in the same cycle returns the old byte; the new byte is visible after the edge.
- Timing: CPU_CLR_N is 0 in every cycle where state is not RUN. The CPU's 1 Hz enable is unaffected.
- Reset mid-load: everything returns to the reset values immediately, including memory.

Optional Feature:
- Macro: LOADER_CHKSUM_EN.
- Defined:
  - LOAD accepts DEPTH+1 bytes; the last byte is a checksum and is not stored.
  - On the checksum handshake: if (sum of the DEPTH data bytes + checksum) mod 256 == 0 -> RUN with LOADED pulse; otherwise -> ERROR.
  - The running sum is 8 bits, wraps, and clears on entry to LOAD.
  - ERROR: ERR = 1, CPU_CLR_N = 0, IN_READY = 0, RUN_REQ ignored. LOAD_REQ -> LOAD and clears ERR.
  - WPTR stays at 0 after the wrap, while the checksum byte is awaited.
- Not defined: exactly DEPTH bytes per load, no ERROR state, ERR tied 0.

Test Plan:
- Reset: assert CLR_N = 0 mid-cycle -> CPU_CLR_N 0, IN_READY 0, WPTR 0 and CPU_DATA 0 immediately, without waiting for an edge.
- Full load: LOAD_REQ, then bytes 0x00..0x0F with IN_VALID held high -> 16 handshakes, LOADED pulses once, CPU_CLR_N = 1 one cycle after RUN. CPU_ADDR = 5 reads 0x05; CPU_ADDR = 15 reads 0x0F.
- Backpressure gaps: toggle IN_VALID 1/0 with bytes 0xA0..0xAF -> only valid cycles are written, WPTR advances once per handshake, no RUN before the 16th byte.
- Restart: LOAD_REQ together with byte 7 -> byte 7 is not written, WPTR = 0. Reload 0xFF x16 -> all reads 0xFF.
- RUN_REQ from IDLE after reset -> RUN, CPU_CLR_N = 1, all reads 0x00. LOAD_REQ during RUN -> CPU_CLR_N = 0 on the next edge.
- LOADER_CHKSUM_EN: 16 bytes of 0x01 plus checksum 0xF0 -> RUN. Same data plus checksum 0xF1 -> ERR = 1, CPU_CLR_N stays 0. Then LOAD_REQ -> ERR clears.
